float_ops_unit: RTL and testbench

FLOAT_OPS_UNIT -- requirements
Module: float_ops_unit

---
 rtl/float_ops_unit_pkg.sv | 21 ++
 rtl/float_lzc.sv | 15 +
 rtl/float_ops_unit.sv | 173 +++++++++++++++++
 tb/tb_float_ops_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_ops_unit_pkg.sv
// Shared constants for the float operations unit: op encodings, compare codes and
// binary32 field widths.
package float_ops_unit_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned WORD_W = SIGN_W + EXP_W + MAN_W;

  localparam logic [1:0] OP_ADD      = 2'd0;
  localparam logic [1:0] OP_SUB      = 2'd1;
  localparam logic [1:0] OP_FROM_INT = 2'd2;
  localparam logic [1:0] OP_CMP      = 2'd3;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/float_lzc.sv
// 32-bit leading-zero counter; an all-zero word reports 32.
module float_lzc (
  input  logic [31:0] in_word,
  output logic [5:0]  count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (in_word[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/float_ops_unit.sv
// Combinational binary32 add/sub, int-to-float and compare, with hold registers that
// present the last enabled result while en is low.
module float_ops_unit
  import float_ops_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result,
  output logic [1:0]        cmp,
  output logic [31:0]       debug
);

  // Operand fields; exponent 0 is flushed to zero, exponent 255 is infinity.
  logic             a_sign, b_sign_eff;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             a_zero, b_zero, a_inf, b_inf;
  logic [30:0]      a_mag, b_mag;
  logic [23:0]      a_sig, b_sig;

  assign a_sign     = a[31];
  assign b_sign_eff = b[31] ^ (op == OP_SUB);
  assign a_exp      = a[30:23];
  assign b_exp      = b[30:23];
  assign a_zero     = (a_exp == '0);
  assign b_zero     = (b_exp == '0);
  assign a_inf      = (a_exp == EXP_MAX);
  assign b_inf      = (b_exp == EXP_MAX);
  assign a_mag      = a_zero ? '0 : a[30:0];
  assign b_mag      = b_zero ? '0 : b[30:0];
  assign a_sig      = a_zero ? '0 : {1'b1, a[22:0]};
  assign b_sig      = b_zero ? '0 : {1'b1, b[22:0]};

  // Adder: larger magnitude first so an effective subtract never goes negative.
  logic             a_is_big, big_sign, eff_sub;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [23:0]      big_sig, small_sig;
  logic [26:0]      big_ext, small_ext, add_sum;

  assign a_is_big  = (a_mag >= b_mag);
  assign big_sign  = a_is_big ? a_sign : b_sign_eff;
  assign big_exp   = a_is_big ? a_exp : b_exp;
  assign small_exp = a_is_big ? b_exp : a_exp;
  assign big_sig   = a_is_big ? a_sig : b_sig;
  assign small_sig = a_is_big ? b_sig : a_sig;
  assign exp_diff  = big_exp - small_exp;
  assign eff_sub   = a_sign ^ b_sign_eff;

  // Two guard bits below the significand; shifts of 26 or more leave nothing.
  assign big_ext   = {1'b0, big_sig, 2'b00};
  assign small_ext = {1'b0, small_sig, 2'b00} >> exp_diff;
  assign add_sum   = eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);

  // Int conversion operand magnitude; 0x80000000 negates to itself, which is correct unsigned.
  logic        int_neg;
  logic [31:0] int_abs;

  assign int_neg = a[31];
  assign int_abs = int_neg ? (~a + 32'd1) : a;

  // One leading-zero counter serves both normalizers.
  logic [31:0] lzc_in, norm_shifted;
  logic [5:0]  lz;
  logic [22:0] norm_man;

  assign lzc_in = (op == OP_FROM_INT) ? int_abs : {add_sum, 5'b0};

  float_lzc u_lzc (
    .in_word (lzc_in),
    .count   (lz)
  );

  assign norm_shifted = lzc_in << lz;
  assign norm_man     = 23'(norm_shifted >> 8);

  // The significand's leading one sits at sum bit 25, so no shift means exponent + 1.
  logic signed [9:0] add_exp;
  logic [WORD_W-1:0] add_res;

  assign add_exp = $signed({2'b00, big_exp}) + 10'sd1 - $signed({4'b0000, lz});

  always_comb begin
    add_res = '0;
    if (a_inf) begin
      add_res = {a_sign, EXP_MAX, 23'd0};
    end else if (b_inf) begin
      add_res = {b_sign_eff, EXP_MAX, 23'd0};
    end else if (add_sum == '0) begin
      add_res = '0;
    end else if (add_exp >= 10'sd255) begin
      add_res = {big_sign, EXP_MAX, 23'd0};
    end else if (add_exp <= 10'sd0) begin
      add_res = '0;
    end else begin
      add_res = {big_sign, add_exp[7:0], norm_man};
    end
  end

  logic [EXP_W-1:0]  int_exp;
  logic [WORD_W-1:0] int_res;

  assign int_exp = 8'd158 - {2'b00, lz};
  assign int_res = (int_abs == '0) ? '0 : {int_neg, int_exp, norm_man};

  // Compare keys: NaN folds onto infinity and zeros lose their sign.
  logic [30:0] a_key, b_key;
  logic        a_neg, b_neg;
  logic [1:0]  cmp_res;

  assign a_key = a_inf ? {EXP_MAX, 23'd0} : a_mag;
  assign b_key = b_inf ? {EXP_MAX, 23'd0} : b_mag;
  assign a_neg = a[31] && (a_key != '0);
  assign b_neg = b[31] && (b_key != '0);

  always_comb begin
    cmp_res = CMP_EQ;
    if (a_neg != b_neg) begin
      cmp_res = a_neg ? CMP_LT : CMP_GT;
    end else if (a_key == b_key) begin
      cmp_res = CMP_EQ;
    end else if (!a_neg) begin
      cmp_res = (a_key < b_key) ? CMP_LT : CMP_GT;
    end else begin
      cmp_res = (a_key > b_key) ? CMP_LT : CMP_GT;
    end
  end

  logic [WORD_W-1:0] result_d;
  logic [1:0]        cmp_d;
  logic [31:0]       debug_d;
  logic [5:0]        shift_used;

  always_comb begin
    result_d   = '0;
    cmp_d      = CMP_EQ;
    shift_used = lz;
    unique case (op)
      OP_ADD, OP_SUB: result_d = add_res;
      OP_FROM_INT:    result_d = int_res;
      OP_CMP: begin
        cmp_d      = cmp_res;
        shift_used = '0;
      end
      default: result_d = '0;
    endcase
  end

  assign debug_d = {6'd0, op, result_d[30:23], 10'd0, shift_used};

  logic [WORD_W-1:0] result_q;
  logic [1:0]        cmp_q;
  logic [31:0]       debug_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      cmp_q    <= CMP_EQ;
      debug_q  <= '0;
    end else if (en) begin
      result_q <= result_d;
      cmp_q    <= cmp_d;
      debug_q  <= debug_d;
    end
  end

  assign result = en ? result_d : result_q;
  assign cmp    = en ? cmp_d : cmp_q;
  assign debug  = en ? debug_d : debug_q;

endmodule

// File: tb/tb_float_ops_unit.sv
// Directed self-checking bench for float_ops_unit.
module tb_float_ops_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [1:0]  cmp;
  logic [31:0] debug;

  int checks;
  int errors;

  float_ops_unit dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .cmp    (cmp),
    .debug  (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    #2;
    checks++;
    if (result !== 32'h0 || cmp !== 2'b00 || debug !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: result=%h cmp=%b debug=%h required 00000000/00/00000000",
               result, cmp, debug);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [1:0]  ops[6]  = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    logic [31:0] av[6]   = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h4B800000,
                             32'h3F800000, 32'h40400000};
    logic [31:0] bv[6]   = '{32'h40000000, 32'h3F800000, 32'hBF000000, 32'h3F800000,
                             32'h3F7FFFFF, 32'h3F800000};
    logic [31:0] exp_r[6] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h4B800000,
                              32'h33800000, 32'h40000000};
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = ops[i];
      a  = av[i];
      b  = bv[i];
      #1;
      checks++;
      if (result !== exp_r[i] || cmp !== 2'b00) begin
        errors++;
        $display("FAIL add_sub[%0d]: result=%h cmp=%b required %h/00", i, result, cmp, exp_r[i]);
      end
    end
    op = 2'd0;
    a  = 32'h3F800000;
    b  = 32'h40000000;
    #1;
    checks++;
    if (debug !== 32'h00800001) begin
      errors++;
      $display("FAIL add_debug: debug=%h required 00800001", debug);
    end
  endtask

  task automatic test_from_int();
    logic [31:0] av[5]    = '{32'd5, 32'hFFFFFFFF, 32'h01000001, 32'h80000000, 32'd0};
    logic [31:0] exp_r[5] = '{32'h40A00000, 32'hBF800000, 32'h4B800000, 32'hCF000000,
                              32'h00000000};
    en = 1'b1;
    op = 2'd2;
    b  = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      a = av[i];
      #1;
      checks++;
      if (result !== exp_r[i] || cmp !== 2'b00) begin
        errors++;
        $display("FAIL from_int[%0d]: result=%h cmp=%b required %h/00", i, result, cmp, exp_r[i]);
      end
    end
    a = 32'd5;
    #1;
    checks++;
    if (debug !== 32'h0281001D) begin
      errors++;
      $display("FAIL from_int_debug: debug=%h required 0281001D", debug);
    end
  endtask

  task automatic test_cmp();
    logic [31:0] av[6]  = '{32'h3F800000, 32'h40000000, 32'h80000000, 32'hBF800000,
                            32'hC0000000, 32'h3F800000};
    logic [31:0] bv[6]  = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                            32'hBF800000, 32'h3F800000};
    logic [1:0]  exp_c[6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    en = 1'b1;
    op = 2'd3;
    for (int i = 0; i < 6; i++) begin
      a = av[i];
      b = bv[i];
      #1;
      checks++;
      if (cmp !== exp_c[i] || result !== 32'h0) begin
        errors++;
        $display("FAIL cmp[%0d]: cmp=%b result=%h required %b/00000000",
                 i, cmp, result, exp_c[i]);
      end
    end
    checks++;
    if (debug !== 32'h03000000) begin
      errors++;
      $display("FAIL cmp_debug: debug=%h required 03000000", debug);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] av[4]    = '{32'h7F7FFFFF, 32'h00400000, 32'hFF800000, 32'h00800000};
    logic [31:0] bv[4]    = '{32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00800001};
    logic [1:0]  ops[4]   = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic [31:0] exp_r[4] = '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h00000000};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      a  = av[i];
      b  = bv[i];
      #1;
      checks++;
      if (result !== exp_r[i]) begin
        errors++;
        $display("FAIL boundary[%0d]: result=%h required %h", i, result, exp_r[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b1;
    op = 2'd0;
    a  = 32'h3F800000;
    b  = 32'h40000000;
    @(posedge clk);
    #1;
    en = 1'b0;
    a  = 32'h41200000;
    b  = 32'hC0000000;
    op = 2'd3;
    #1;
    checks++;
    if (result !== 32'h40400000 || cmp !== 2'b00 || debug !== 32'h00800001) begin
      errors++;
      $display("FAIL hold: result=%h cmp=%b debug=%h required 40400000/00/00800001",
               result, cmp, debug);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h40400000) begin
      errors++;
      $display("FAIL hold_second_cycle: result=%h required 40400000", result);
    end
  endtask

  task automatic test_back_to_back();
    // op switches each cycle; the last enabled op is CMP 1.0 vs 2.0.
    @(negedge clk);
    en = 1'b1;
    op = 2'd2;
    a  = 32'd5;
    @(negedge clk);
    op = 2'd1;
    a  = 32'h40400000;
    b  = 32'h3F800000;
    #1;
    checks++;
    if (result !== 32'h40000000) begin
      errors++;
      $display("FAIL b2b_sub: result=%h required 40000000", result);
    end
    @(negedge clk);
    op = 2'd3;
    a  = 32'h3F800000;
    b  = 32'h40000000;
    @(posedge clk);
    #1;
    en = 1'b0;
    a  = '0;
    #1;
    checks++;
    if (cmp !== 2'b01 || result !== 32'h0 || debug !== 32'h03000000) begin
      errors++;
      $display("FAIL b2b_hold_cmp: cmp=%b result=%h debug=%h required 01/00000000/03000000",
               cmp, result, debug);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    en = 1'b1;
    op = 2'd0;
    a  = 32'h3F800000;
    b  = 32'h40000000;
    @(posedge clk);
    #1;
    en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0 || cmp !== 2'b00 || debug !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: result=%h cmp=%b debug=%h required 00000000/00/00000000",
               result, cmp, debug);
    end
    // Live outputs under reset, but no capture.
    en = 1'b1;
    #1;
    checks++;
    if (result !== 32'h40400000) begin
      errors++;
      $display("FAIL reset_live: result=%h required 40400000", result);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0 || debug !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_capture: result=%h debug=%h required 00000000/00000000",
               result, debug);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub();
    test_from_int();
    test_cmp();
    test_boundaries();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
